// File: rtl/dht_pkg.sv
// Shared types, error codes and helpers for the single-wire DHT sensor reader.
package dht_pkg;

   localparam int DATA_W = 40;

   localparam logic [1:0] ERR_NONE = 2'd0;
   localparam logic [1:0] ERR_RESP = 2'd1;
   localparam logic [1:0] ERR_BIT  = 2'd2;
   localparam logic [1:0] ERR_CSUM = 2'd3;

   typedef enum logic [3:0] {
      ST_IDLE      = 4'd0,
      ST_START_LOW = 4'd1,
      ST_WAIT_RESP = 4'd2,
      ST_RESP_LOW  = 4'd3,
      ST_RESP_HIGH = 4'd4,
      ST_BIT_LOW   = 4'd5,
      ST_BIT_HIGH  = 4'd6,
      ST_CHECK     = 4'd7,
      ST_ERR       = 4'd8
   } state_t;

   // Frame layout MSB first: hum_int, hum_dec, temp_int, temp_dec, checksum.
   function automatic logic csum_ok(input logic [DATA_W-1:0] frame);
      logic [7:0] sum;
      sum = frame[39:32] + frame[31:24] + frame[23:16] + frame[15:8];
      return (sum == frame[7:0]);
   endfunction

   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/us_tick_gen.sv
// Divides the system clock down to a one-cycle enable every microsecond.
module us_tick_gen #(
   parameter int CLK_FREQ_HZ = 100_000_000
) (
   input  logic clk,
   input  logic rst_n,
   output logic tick
);

   localparam int DIV = (CLK_FREQ_HZ / 1_000_000 > 0) ? CLK_FREQ_HZ / 1_000_000 : 1;
   localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] r_cnt;
   logic          r_tick;

   // Free-running divider; the tick is registered so it is glitch-free.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_cnt  <= '0;
         r_tick <= 1'b0;
      end else if (r_cnt == LAST) begin
         r_cnt  <= '0;
         r_tick <= 1'b1;
      end else begin
         r_cnt  <= r_cnt + 1'b1;
         r_tick <= 1'b0;
      end
   end

   assign tick = r_tick;

endmodule

// File: rtl/dht_sensor_reader.sv
// Single-wire humidity/temperature reader: start pulse, response handshake, 40-bit read, checksum.
// Optional DHT_GLITCH_FILTER_EN adds a 3-sample majority filter behind the line synchronizer.
module dht_sensor_reader
   import dht_pkg::*;
#(
   parameter int CLK_FREQ_HZ   = 100_000_000,
   parameter int START_LOW_US  = 18000,
   parameter int TIMEOUT_US    = 200,
   parameter int BIT_THRESH_US = 50
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       line_in,
   output logic       drive_en,
   output logic       drive_data,
   output logic       busy,
   output logic       valid,
   output logic       error,
   output logic [1:0] err_code,
   output logic [7:0] hum_int,
   output logic [7:0] hum_dec,
   output logic [7:0] temp_int,
   output logic [7:0] temp_dec
);

   localparam int PH_MAX = (START_LOW_US > TIMEOUT_US) ? START_LOW_US : TIMEOUT_US;
   localparam int PH_W   = $clog2(PH_MAX + 2);
   localparam logic [PH_W-1:0] START_LAST = PH_W'(START_LOW_US - 1);
   localparam logic [PH_W-1:0] TMO_LIM    = PH_W'(TIMEOUT_US);
   localparam logic [PH_W-1:0] BIT_THR    = PH_W'(BIT_THRESH_US);
   localparam logic [5:0]      LAST_BIT   = 6'(DATA_W - 1);

   logic              w_tick;
   logic              r_sync1;
   logic              r_sync2;
   logic              w_line;
   logic              r_line_prev;
   logic              w_fall;
   state_t            r_state;
   state_t            w_state_nx;
   logic [PH_W-1:0]   r_phase;
   logic              w_phase_inc;
   logic              w_expired;
   logic              w_shift;
   logic              w_new_bit;
   logic              w_csum_ok;
   logic [1:0]        w_err_code_nx;
   logic [5:0]        r_bit_cnt;
   logic [DATA_W-1:0] r_frame;
   logic              r_drive_en;
   logic              r_busy;
   logic              r_valid;
   logic              r_error;
   logic [1:0]        r_err_code;
   logic [7:0]        r_hum_int;
   logic [7:0]        r_hum_dec;
   logic [7:0]        r_temp_int;
   logic [7:0]        r_temp_dec;

   us_tick_gen #(.CLK_FREQ_HZ(CLK_FREQ_HZ)) u_tick (
      .clk   (clk),
      .rst_n (rst_n),
      .tick  (w_tick)
   );

   // Two-flop synchronizer; idles high like the pulled-up bus.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
      end else begin
         r_sync1 <= line_in;
         r_sync2 <= r_sync1;
      end
   end

`ifdef DHT_GLITCH_FILTER_EN
   logic [1:0] r_hist;
   logic       r_line_flt;

   // Majority over the current and two previous samples rejects one-cycle glitches.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_hist     <= 2'b11;
         r_line_flt <= 1'b1;
      end else begin
         r_hist     <= {r_hist[0], r_sync2};
         r_line_flt <= maj3(r_sync2, r_hist[0], r_hist[1]);
      end
   end

   assign w_line = r_line_flt;
`else
   assign w_line = r_sync2;
`endif

   // Previous line level for falling-edge detection.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_line_prev <= 1'b1;
      end else begin
         r_line_prev <= w_line;
      end
   end

   assign w_fall    = r_line_prev & ~w_line;
   assign w_expired = w_tick && (r_phase >= TMO_LIM);
   assign w_new_bit = (r_phase > BIT_THR);
   assign w_csum_ok = csum_ok(r_frame);

   // FSM state register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nx;
      end
   end

   // Next-state decode; a level-sensitive line check takes priority over the timeout.
   always_comb begin
      w_state_nx    = r_state;
      w_phase_inc   = 1'b0;
      w_shift       = 1'b0;
      w_err_code_nx = r_err_code;
      case (r_state)
         ST_IDLE: begin
            if (start && !r_valid) begin
               w_state_nx = ST_START_LOW;
            end else begin
               w_state_nx = ST_IDLE;
            end
         end
         ST_START_LOW: begin
            if (w_tick && (r_phase == START_LAST)) begin
               w_state_nx = ST_WAIT_RESP;
            end else begin
               w_phase_inc = w_tick;
            end
         end
         ST_WAIT_RESP: begin
            if (w_fall) begin
               w_state_nx = ST_RESP_LOW;
            end else if (w_expired) begin
               w_state_nx    = ST_ERR;
               w_err_code_nx = ERR_RESP;
            end else begin
               w_phase_inc = w_tick;
            end
         end
         ST_RESP_LOW: begin
            if (w_line) begin
               w_state_nx = ST_RESP_HIGH;
            end else if (w_expired) begin
               w_state_nx    = ST_ERR;
               w_err_code_nx = ERR_RESP;
            end else begin
               w_phase_inc = w_tick;
            end
         end
         ST_RESP_HIGH: begin
            if (!w_line) begin
               w_state_nx = ST_BIT_LOW;
            end else if (w_expired) begin
               w_state_nx    = ST_ERR;
               w_err_code_nx = ERR_RESP;
            end else begin
               w_phase_inc = w_tick;
            end
         end
         ST_BIT_LOW: begin
            if (w_line) begin
               w_state_nx = ST_BIT_HIGH;
            end else if (w_expired) begin
               w_state_nx    = ST_ERR;
               w_err_code_nx = ERR_BIT;
            end else begin
               w_phase_inc = w_tick;
            end
         end
         ST_BIT_HIGH: begin
            if (!w_line) begin
               w_shift = 1'b1;
               if (r_bit_cnt == LAST_BIT) begin
                  w_state_nx = ST_CHECK;
               end else begin
                  w_state_nx = ST_BIT_LOW;
               end
            end else if (w_expired) begin
               w_state_nx    = ST_ERR;
               w_err_code_nx = ERR_BIT;
            end else begin
               w_phase_inc = w_tick;
            end
         end
         ST_CHECK: begin
            if (w_csum_ok) begin
               w_state_nx = ST_IDLE;
            end else begin
               w_state_nx    = ST_ERR;
               w_err_code_nx = ERR_CSUM;
            end
         end
         ST_ERR: begin
            w_state_nx = ST_IDLE;
         end
         default: begin
            w_state_nx = ST_IDLE;
         end
      endcase
   end

   // Phase counter counts microsecond ticks and restarts on every state change.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_phase <= '0;
      end else if (w_state_nx != r_state) begin
         r_phase <= '0;
      end else if (w_phase_inc) begin
         r_phase <= r_phase + 1'b1;
      end
   end

   // Bit shift register and bit counter, cleared while idle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_frame   <= '0;
         r_bit_cnt <= '0;
      end else if (r_state == ST_IDLE) begin
         r_frame   <= '0;
         r_bit_cnt <= '0;
      end else if (w_shift) begin
         r_frame   <= {r_frame[DATA_W-2:0], w_new_bit};
         r_bit_cnt <= r_bit_cnt + 6'd1;
      end
   end

   // Registered outputs follow the next state so busy falls as valid/error rise.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_drive_en <= 1'b0;
         r_busy     <= 1'b0;
         r_valid    <= 1'b0;
         r_error    <= 1'b0;
         r_err_code <= ERR_NONE;
         r_hum_int  <= 8'd0;
         r_hum_dec  <= 8'd0;
         r_temp_int <= 8'd0;
         r_temp_dec <= 8'd0;
      end else begin
         r_drive_en <= (w_state_nx == ST_START_LOW);
         r_busy     <= !((w_state_nx == ST_IDLE) || (w_state_nx == ST_ERR));
         r_valid    <= (r_state == ST_CHECK) && w_csum_ok;
         r_error    <= (w_state_nx == ST_ERR);
         if (w_state_nx == ST_ERR) begin
            r_err_code <= w_err_code_nx;
         end
         if ((r_state == ST_CHECK) && w_csum_ok) begin
            r_hum_int  <= r_frame[39:32];
            r_hum_dec  <= r_frame[31:24];
            r_temp_int <= r_frame[23:16];
            r_temp_dec <= r_frame[15:8];
         end
      end
   end

   assign drive_en   = r_drive_en;
   assign drive_data = 1'b0;
   assign busy       = r_busy;
   assign valid      = r_valid;
   assign error      = r_error;
   assign err_code   = r_err_code;
   assign hum_int    = r_hum_int;
   assign hum_dec    = r_hum_dec;
   assign temp_int   = r_temp_int;
   assign temp_dec   = r_temp_dec;

endmodule
